// File: rtl/waste_collect_scheduler.sv
// waste_collect_scheduler: round-robin collection requests for full sorter bins, with clear pulse and ack timeout
module waste_collect_scheduler #(
  parameter int NUM_BINS    = 7,
  parameter int LEVEL_W     = 8,
  parameter int FULL_THRESH = 200,
  parameter int ACK_TIMEOUT = 255,
  parameter int SETTLE      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_BINS*LEVEL_W-1:0] bin_level,
  input  logic                        req_ready,
  input  logic                        err_clr,
  output logic                        req_valid,
  output logic [2:0]                  req_bin,
  output logic [LEVEL_W-1:0]          req_level,
  output logic [NUM_BINS-1:0]         clr_bin,
  output logic [NUM_BINS-1:0]         full_flags,
  output logic                        busy,
  output logic                        timeout_err
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CLEAR, S_SETL} state_t;
  state_t state, state_d;
  logic [NUM_BINS*LEVEL_W-1:0] lvl_q;
  logic [NUM_BINS-1:0] full_d;
  logic [2:0] ptr, sel, nxt;
  logic [3:0] j;
  logic found, ld, acc, tmo;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  for (genvar i = 0; i < NUM_BINS; i++) begin : g_full
    assign full_d[i] = bin_level[i*LEVEL_W +: LEVEL_W] >= LEVEL_W'(FULL_THRESH);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      full_flags <= '0;
      lvl_q <= '0;
    end else begin
      full_flags <= full_d;
      lvl_q <= bin_level;
    end
  // first full bin at or after the pointer, wrapping at NUM_BINS
  always_comb begin
    found = 1'b0;
    sel = ptr;
    j = '0;
    for (int k = 0; k < NUM_BINS; k++) begin
      j = 4'(ptr) + 4'(k);
      j = (j >= 4'(NUM_BINS)) ? j - 4'(NUM_BINS) : j;
      if (!found && full_flags[j[2:0]]) begin
        found = 1'b1;
        sel = j[2:0];
      end
    end
  end
  assign nxt = (req_bin == 3'(NUM_BINS - 1)) ? 3'd0 : req_bin + 3'd1;
  always_comb begin
    state_d = state;
    ld = 1'b0;
    acc = 1'b0;
    tmo = 1'b0;
    case (state)
      S_IDLE: begin
        ld = found;
        state_d = found ? S_REQ : S_IDLE;
      end
      S_REQ: begin
        acc = req_ready;
        tmo = !req_ready && tcnt == TW'(ACK_TIMEOUT - 1);
        state_d = acc ? S_CLEAR : tmo ? S_IDLE : S_REQ;
      end
      S_CLEAR: state_d = S_SETL;
      S_SETL: state_d = (scnt == SW'(SETTLE - 1)) ? S_IDLE : S_SETL;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      ptr <= '0;
      req_bin <= '0;
      req_level <= '0;
      tcnt <= '0;
      scnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_d;
      if (ld) begin
        req_bin <= sel;
        req_level <= lvl_q[sel*LEVEL_W +: LEVEL_W];
      end
      if (tmo || state == S_CLEAR) ptr <= nxt;
      tcnt <= (state == S_REQ && !acc && !tmo) ? tcnt + 1'b1 : '0;
      scnt <= (state == S_SETL && state_d == S_SETL) ? scnt + 1'b1 : '0;
      timeout_err <= tmo | (timeout_err & ~err_clr);
    end
  assign req_valid = state == S_REQ;
  assign clr_bin = (state == S_CLEAR) ? NUM_BINS'(1) << req_bin : '0;
  assign busy = state != S_IDLE;
endmodule
